// File: rtl/tlb_unit_pkg.sv
// tlb_unit_pkg
// Shared definitions for the TLB block: invtlb operation encodings, the two
// supported page sizes, the per-entry storage layout and a page-size decode
// helper. Imported by tlb_match and tlb_unit.
package tlb_unit_pkg;

  // invtlb operation encodings; values 7..31 are accepted and ignored
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GASID_VA   = 5'd6;

  // page size exponents (4KB and 4MB pages)
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  // translation data for one half (even or odd page) of an entry
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  // one entry minus its E bit; E lives in a separate reset vector so that
  // the bulk of the entry storage needs no reset
  typedef struct packed {
    logic [18:0] vppn;
    logic        ps4m;
    logic [9:0]  asid;
    logic        g;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  // page size flag back to the architectural exponent
  function automatic logic [5:0] ps_decode(input logic ps4m);
    return ps4m ? PS_4M : PS_4K;
  endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// tlb_unit_if
// One TLB search port: request/key from the requester, registered result
// back from the TLB.
//   master : drives req, vppn, va_bit12, asid; receives the result fields
//   slave  : the TLB side
// Result fields: rvalid, found, index (IDXW), ppn(20), ps(6), plv(2), mat(2),
// d, v, multihit.
interface tlb_unit_if #(
  parameter int IDXW = 4
);
  logic            req;
  logic [18:0]     vppn;
  logic            va_bit12;
  logic [9:0]      asid;
  logic            rvalid;
  logic            found;
  logic [IDXW-1:0] index;
  logic [19:0]     ppn;
  logic [5:0]      ps;
  logic [1:0]      plv;
  logic [1:0]      mat;
  logic            d;
  logic            v;
  logic            multihit;

  modport master (
    output req, vppn, va_bit12, asid,
    input  rvalid, found, index, ppn, ps, plv, mat, d, v, multihit
  );

  modport slave (
    input  req, vppn, va_bit12, asid,
    output rvalid, found, index, ppn, ps, plv, mat, d, v, multihit
  );
endinterface

// File: rtl/tlb_unit_match.sv
// tlb_match
// Purely combinational key compare of one search key against every entry.
// Ports:
//   key_vppn, key_asid : search key
//   e, vppn, ps4m, asid, g : per-entry compare fields (packed, one per entry)
//   match              : one bit per entry, set when that entry hits
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int TLBNUM = 16
) (
  input  logic [18:0]              key_vppn,
  input  logic [9:0]               key_asid,
  input  logic [TLBNUM-1:0]        e,
  input  logic [TLBNUM-1:0][18:0]  vppn,
  input  logic [TLBNUM-1:0]        ps4m,
  input  logic [TLBNUM-1:0][9:0]   asid,
  input  logic [TLBNUM-1:0]        g,
  output logic [TLBNUM-1:0]        match
);

  // a 4MB page ignores the low nine vppn bits; global entries ignore asid
  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = e[i]
               && (vppn[i][18:9] == key_vppn[18:9])
               && (ps4m[i] || (vppn[i][8:0] == key_vppn[8:0]))
               && (g[i] || (asid[i] == key_asid));
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// tlb_unit
// Fully associative TLB with two registered search ports, an entry write
// port, a combinational read port, invtlb invalidation and a fill-index
// generator for TLBFILL.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   s0, s1             : search ports (tlb_unit_if slave), fetch and load/store
//   invtlb_valid/op, inv_asid, inv_vppn : invalidate request
//   we, w_index, w_*   : entry write
//   r_index, r_*       : entry read, combinational
//   fill_index, fill_adv : replacement index and its advance strobe
// Build option: define TLB_LFSR_FILL_EN to derive fill_index from an 8-bit
// LFSR instead of a round-robin counter.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  tlb_unit_if.slave       s0,
  tlb_unit_if.slave       s1,
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1,
  output logic [IDXW-1:0] fill_index,
  input  logic            fill_adv
);

  logic [TLBNUM-1:0] e_q;
  logic [TLBNUM-1:0] e_next;
  logic [TLBNUM-1:0] inv_sel;
  tlb_entry_t        ent [TLBNUM];

  logic [TLBNUM-1:0]       ent_ps4m;
  logic [TLBNUM-1:0]       ent_g;
  logic [TLBNUM-1:0][18:0] ent_vppn;
  logic [TLBNUM-1:0][9:0]  ent_asid;

  logic              key_req   [2];
  logic [18:0]       key_vppn  [2];
  logic              key_bit12 [2];
  logic [9:0]        key_asid  [2];
  logic [TLBNUM-1:0] match     [2];

  logic              hit     [2];
  logic [IDXW-1:0]   hit_idx [2];
  logic              multi   [2];
  logic              odd     [2];
  tlb_page_t         page    [2];
  logic [5:0]        res_ps  [2];

  logic              rvalid_q [2];
  logic              found_q  [2];
  logic              multi_q  [2];
  logic [IDXW-1:0]   idx_q    [2];
  tlb_page_t         page_q   [2];
  logic [5:0]        ps_q     [2];

  assign key_req[0]   = s0.req;
  assign key_vppn[0]  = s0.vppn;
  assign key_bit12[0] = s0.va_bit12;
  assign key_asid[0]  = s0.asid;
  assign key_req[1]   = s1.req;
  assign key_vppn[1]  = s1.vppn;
  assign key_bit12[1] = s1.va_bit12;
  assign key_asid[1]  = s1.asid;

  // flatten the compare fields so the match sub-module sees only what it uses
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      ent_vppn[i] = ent[i].vppn;
      ent_ps4m[i] = ent[i].ps4m;
      ent_asid[i] = ent[i].asid;
      ent_g[i]    = ent[i].g;
    end
  end

  tlb_match #(.TLBNUM(TLBNUM)) u_match0 (
    .key_vppn (key_vppn[0]),
    .key_asid (key_asid[0]),
    .e        (e_q),
    .vppn     (ent_vppn),
    .ps4m     (ent_ps4m),
    .asid     (ent_asid),
    .g        (ent_g),
    .match    (match[0])
  );

  tlb_match #(.TLBNUM(TLBNUM)) u_match1 (
    .key_vppn (key_vppn[1]),
    .key_asid (key_asid[1]),
    .e        (e_q),
    .vppn     (ent_vppn),
    .ps4m     (ent_ps4m),
    .asid     (ent_asid),
    .g        (ent_g),
    .match    (match[1])
  );

  // priority encode towards the lowest index; multihit is "more than one bit
  // set", found by clearing the lowest set bit and testing what remains
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]     = 1'b0;
      hit_idx[p] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (match[p][i]) begin
          hit[p]     = 1'b1;
          hit_idx[p] = IDXW'(i);
        end
      end
      multi[p]  = |(match[p] & (match[p] - TLBNUM'(1)));
      odd[p]    = ent[hit_idx[p]].ps4m ? key_vppn[p][8] : key_bit12[p];
      page[p]   = odd[p] ? ent[hit_idx[p]].p1 : ent[hit_idx[p]].p0;
      res_ps[p] = ps_decode(ent[hit_idx[p]].ps4m);
      if (!hit[p]) begin
        page[p]   = '0;
        res_ps[p] = '0;
      end
    end
  end

  // search results are captured from the pre-update entry state, so a write
  // or invalidate in the same cycle does not affect the reported result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= 1'b0;
        found_q[p]  <= 1'b0;
        multi_q[p]  <= 1'b0;
        idx_q[p]    <= '0;
        page_q[p]   <= '0;
        ps_q[p]     <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= key_req[p];
        if (key_req[p]) begin
          found_q[p] <= hit[p];
          multi_q[p] <= multi[p];
          idx_q[p]   <= hit_idx[p];
          page_q[p]  <= page[p];
          ps_q[p]    <= res_ps[p];
        end
      end
    end
  end

  assign s0.rvalid   = rvalid_q[0];
  assign s0.found    = found_q[0];
  assign s0.multihit = multi_q[0];
  assign s0.index    = idx_q[0];
  assign s0.ppn      = page_q[0].ppn;
  assign s0.plv      = page_q[0].plv;
  assign s0.mat      = page_q[0].mat;
  assign s0.d        = page_q[0].d;
  assign s0.v        = page_q[0].v;
  assign s0.ps       = ps_q[0];
  assign s1.rvalid   = rvalid_q[1];
  assign s1.found    = found_q[1];
  assign s1.multihit = multi_q[1];
  assign s1.index    = idx_q[1];
  assign s1.ppn      = page_q[1].ppn;
  assign s1.plv      = page_q[1].plv;
  assign s1.mat      = page_q[1].mat;
  assign s1.d        = page_q[1].d;
  assign s1.v        = page_q[1].v;
  assign s1.ps       = ps_q[1];

  // invtlb entry selection; the vppn compare follows the same page-size rule
  // as a search
  always_comb begin
    inv_sel = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      logic vm;
      logic am;
      vm = (ent[i].vppn[18:9] == inv_vppn[18:9])
        && (ent[i].ps4m || (ent[i].vppn[8:0] == inv_vppn[8:0]));
      am = (ent[i].asid == inv_asid);
      case (invtlb_op)
        INV_ALL0, INV_ALL1: inv_sel[i] = 1'b1;
        INV_G:              inv_sel[i] = ent[i].g;
        INV_NG:             inv_sel[i] = !ent[i].g;
        INV_NG_ASID:        inv_sel[i] = !ent[i].g && am;
        INV_NG_ASID_VA:     inv_sel[i] = !ent[i].g && am && vm;
        INV_GASID_VA:       inv_sel[i] = (ent[i].g || am) && vm;
        default:            inv_sel[i] = 1'b0;
      endcase
    end
  end

  // invalidation first, then the write wins for its own entry
  always_comb begin
    e_next = e_q;
    if (invtlb_valid) e_next = e_q & ~inv_sel;
    if (we) e_next[w_index] = w_e;
  end

  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_next;
  end

  // entry payload has no reset; E gates every use of it
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      ent[w_index].vppn    <= w_vppn;
      ent[w_index].ps4m    <= (w_ps == PS_4M);
      ent[w_index].asid    <= w_asid;
      ent[w_index].g       <= w_g;
      ent[w_index].p0.ppn  <= w_ppn0;
      ent[w_index].p0.plv  <= w_plv0;
      ent[w_index].p0.mat  <= w_mat0;
      ent[w_index].p0.d    <= w_d0;
      ent[w_index].p0.v    <= w_v0;
      ent[w_index].p1.ppn  <= w_ppn1;
      ent[w_index].p1.plv  <= w_plv1;
      ent[w_index].p1.mat  <= w_mat1;
      ent[w_index].p1.d    <= w_d1;
      ent[w_index].p1.v    <= w_v1;
    end
  end

  assign r_e    = e_q[r_index];
  assign r_vppn = ent[r_index].vppn;
  assign r_ps   = ps_decode(ent[r_index].ps4m);
  assign r_asid = ent[r_index].asid;
  assign r_g    = ent[r_index].g;
  assign r_ppn0 = ent[r_index].p0.ppn;
  assign r_plv0 = ent[r_index].p0.plv;
  assign r_mat0 = ent[r_index].p0.mat;
  assign r_d0   = ent[r_index].p0.d;
  assign r_v0   = ent[r_index].p0.v;
  assign r_ppn1 = ent[r_index].p1.ppn;
  assign r_plv1 = ent[r_index].p1.plv;
  assign r_mat1 = ent[r_index].p1.mat;
  assign r_d1   = ent[r_index].p1.d;
  assign r_v1   = ent[r_index].p1.v;

`ifdef TLB_LFSR_FILL_EN
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, never reaches the all-zero state
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset)         lfsr_q <= 8'h01;
    else if (fill_adv) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign fill_index = lfsr_q[IDXW-1:0];
`else
  // round-robin replacement; natural wrap at TLBNUM since it is a power of two
  logic [IDXW-1:0] fill_q;

  always_ff @(posedge clk) begin
    if (reset)         fill_q <= '0;
    else if (fill_adv) fill_q <= fill_q + IDXW'(1);
  end

  assign fill_index = fill_q;
`endif

endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit
// Directed-vector bench for tlb_unit (TLBNUM=16): reset, search hits and
// misses on both ports, 4MB page select, multihit, invtlb operations,
// write/invalidate collision, read port, fill index sequence.
module tb_tlb_unit;
  import tlb_unit_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            invtlb_valid = 1'b0;
  logic [4:0]      invtlb_op = '0;
  logic [9:0]      inv_asid = '0;
  logic [18:0]     inv_vppn = '0;
  logic            we = 1'b0;
  logic [IDXW-1:0] w_index = '0;
  logic            w_e = 1'b0;
  logic [18:0]     w_vppn = '0;
  logic [5:0]      w_ps = '0;
  logic [9:0]      w_asid = '0;
  logic            w_g = 1'b0;
  logic [19:0]     w_ppn0 = '0, w_ppn1 = '0;
  logic [1:0]      w_plv0 = '0, w_plv1 = '0, w_mat0 = '0, w_mat1 = '0;
  logic            w_d0 = 1'b0, w_d1 = 1'b0, w_v0 = 1'b0, w_v1 = 1'b0;
  logic [IDXW-1:0] r_index = '0;
  logic            r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0]     r_vppn;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic [19:0]     r_ppn0, r_ppn1;
  logic [1:0]      r_plv0, r_mat0, r_plv1, r_mat1;
  logic [IDXW-1:0] fill_index;
  logic            fill_adv = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  tlb_unit_if #(.IDXW(IDXW)) s0_if ();
  tlb_unit_if #(.IDXW(IDXW)) s1_if ();

  always #5 clk = ~clk;

  tlb_unit #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .s0(s0_if), .s1(s1_if),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .fill_index(fill_index), .fill_adv(fill_adv)
  );

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // writes a valid entry; page 0 uses plv=2 mat=1 d=1, page 1 plv=3 mat=0 d=0
  task automatic write_entry(input int idx, input logic [18:0] vppn, input logic [5:0] ps,
                             input logic [9:0] asid, input logic g,
                             input logic [19:0] ppn0, input logic [19:0] ppn1);
    we = 1'b1; w_index = idx[IDXW-1:0]; w_e = 1'b1; w_vppn = vppn; w_ps = ps;
    w_asid = asid; w_g = g;
    w_ppn0 = ppn0; w_plv0 = 2'd2; w_mat0 = 2'd1; w_d0 = 1'b1; w_v0 = 1'b1;
    w_ppn1 = ppn1; w_plv1 = 2'd3; w_mat1 = 2'd0; w_d1 = 1'b0; w_v1 = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic search(input int port, input logic [18:0] vppn, input logic bit12, input logic [9:0] asid);
    if (port == 0) begin
      s0_if.req = 1'b1; s0_if.vppn = vppn; s0_if.va_bit12 = bit12; s0_if.asid = asid;
    end else begin
      s1_if.req = 1'b1; s1_if.vppn = vppn; s1_if.va_bit12 = bit12; s1_if.asid = asid;
    end
    tick();
    s0_if.req = 1'b0;
    s1_if.req = 1'b0;
  endtask

  task automatic check_hit(input string tag, input int port, input logic found, input int idx,
                           input logic [19:0] ppn, input logic [5:0] ps, input logic multi);
    if (port == 0) begin
      check_output({tag, ".rvalid"}, 32'(s0_if.rvalid), 32'd1);
      check_output({tag, ".found"}, 32'(s0_if.found), 32'(found));
      check_output({tag, ".index"}, 32'(s0_if.index), 32'(idx));
      check_output({tag, ".ppn"}, 32'(s0_if.ppn), 32'(ppn));
      check_output({tag, ".ps"}, 32'(s0_if.ps), 32'(ps));
      check_output({tag, ".multihit"}, 32'(s0_if.multihit), 32'(multi));
    end else begin
      check_output({tag, ".rvalid"}, 32'(s1_if.rvalid), 32'd1);
      check_output({tag, ".found"}, 32'(s1_if.found), 32'(found));
      check_output({tag, ".index"}, 32'(s1_if.index), 32'(idx));
      check_output({tag, ".ppn"}, 32'(s1_if.ppn), 32'(ppn));
      check_output({tag, ".ps"}, 32'(s1_if.ps), 32'(ps));
      check_output({tag, ".multihit"}, 32'(s1_if.multihit), 32'(multi));
    end
  endtask

  task automatic invtlb(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    invtlb_valid = 1'b1; invtlb_op = op; inv_asid = asid; inv_vppn = vppn;
    tick();
    invtlb_valid = 1'b0;
  endtask

  // fill index model for whichever build is under test
  function automatic logic [7:0] fill_step(input logic [7:0] cur);
`ifdef TLB_LFSR_FILL_EN
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
`else
    return cur + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] fill_seed();
`ifdef TLB_LFSR_FILL_EN
    return 8'h01;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    logic [7:0] fill_m;
    s0_if.req = 1'b0; s0_if.vppn = '0; s0_if.va_bit12 = 1'b0; s0_if.asid = '0;
    s1_if.req = 1'b0; s1_if.vppn = '0; s1_if.va_bit12 = 1'b0; s1_if.asid = '0;

    // reset held while write, invtlb, search and fill_adv are all asserted
    reset = 1'b1;
    we = 1'b1; w_index = 4'd6; w_e = 1'b1; w_ps = PS_4K;
    invtlb_valid = 1'b1; s0_if.req = 1'b1; s1_if.req = 1'b1; fill_adv = 1'b1;
    tick();
    tick();
    we = 1'b0; invtlb_valid = 1'b0; s0_if.req = 1'b0; s1_if.req = 1'b0; fill_adv = 1'b0;
    r_index = 4'd6;
    #1;
    fill_m = fill_seed();
    check_output("rst.s0.rvalid", 32'(s0_if.rvalid), 32'd0);
    check_output("rst.s0.found", 32'(s0_if.found), 32'd0);
    check_output("rst.s1.rvalid", 32'(s1_if.rvalid), 32'd0);
    check_output("rst.s0.ppn", 32'(s0_if.ppn), 32'd0);
    check_output("rst.r_e6", 32'(r_e), 32'd0);
    check_output("rst.fill", 32'(fill_index), 32'(fill_m[IDXW-1:0]));
    reset = 1'b0;
    tick();

    // basic 4KB hit, both pages, and an asid miss
    write_entry(3, 19'h12345, PS_4K, 10'd5, 1'b0, 20'hABCDE, 20'h11111);
    search(0, 19'h12345, 1'b0, 10'd5);
    check_hit("idx3.p0", 0, 1'b1, 3, 20'hABCDE, PS_4K, 1'b0);
    check_output("idx3.p0.plv", 32'(s0_if.plv), 32'd2);
    check_output("idx3.p0.v", 32'(s0_if.v), 32'd1);
    search(1, 19'h12345, 1'b1, 10'd5);
    check_hit("idx3.p1", 1, 1'b1, 3, 20'h11111, PS_4K, 1'b0);
    check_output("idx3.p1.plv", 32'(s1_if.plv), 32'd3);
    check_output("s0.idle.rvalid", 32'(s0_if.rvalid), 32'd0);
    search(0, 19'h12345, 1'b0, 10'd6);
    check_hit("asid.miss", 0, 1'b0, 0, 20'h0, 6'd0, 1'b0);
    tick();
    check_output("after.req0.rvalid", 32'(s0_if.rvalid), 32'd0);

    // 4MB global page: vppn[8] of the key picks the page
    write_entry(7, 19'h12200, PS_4M, 10'd3, 1'b1, 20'h22222, 20'h33333);
    search(0, 19'h123FF, 1'b0, 10'd9);
    check_hit("4m.p1", 0, 1'b1, 7, 20'h33333, PS_4M, 1'b0);
    search(1, 19'h122FF, 1'b1, 10'd9);
    check_hit("4m.p0", 1, 1'b1, 7, 20'h22222, PS_4M, 1'b0);

    // duplicate key: lowest index wins with multihit
    write_entry(2, 19'h40000, PS_4K, 10'd1, 1'b0, 20'h00002, 20'h10002);
    write_entry(9, 19'h40000, PS_4K, 10'd1, 1'b0, 20'h00009, 20'h10009);
    search(0, 19'h40000, 1'b0, 10'd1);
    check_hit("multi", 0, 1'b1, 2, 20'h00002, PS_4K, 1'b1);

    // op4 on asid 5 with a same-cycle search: result predates the clear;
    // idx7 (global 4MB) also covers this key, so both match
    write_entry(10, 19'h50000, PS_4K, 10'd6, 1'b0, 20'h0000A, 20'h1000A);
    s0_if.req = 1'b1; s0_if.vppn = 19'h12345; s0_if.va_bit12 = 1'b0; s0_if.asid = 10'd5;
    invtlb(INV_NG_ASID, 10'd5, 19'h0);
    s0_if.req = 1'b0;
    check_hit("op4.sameclk", 0, 1'b1, 3, 20'hABCDE, PS_4K, 1'b1);
    search(0, 19'h12345, 1'b0, 10'd5);
    check_hit("op4.idx3gone", 0, 1'b1, 7, 20'h33333, PS_4M, 1'b0);
    search(1, 19'h50000, 1'b0, 10'd6);
    check_hit("op4.idx10kept", 1, 1'b1, 10, 20'h0000A, PS_4K, 1'b0);
    invtlb(5'd9, 10'd6, 19'h50000);
    search(1, 19'h50000, 1'b0, 10'd6);
    check_hit("op9.noeffect", 1, 1'b1, 10, 20'h0000A, PS_4K, 1'b0);
    invtlb(INV_G, 10'd0, 19'h0);
    search(0, 19'h12345, 1'b0, 10'd5);
    check_hit("op2.idx7gone", 0, 1'b0, 0, 20'h0, 6'd0, 1'b0);
    search(1, 19'h50000, 1'b0, 10'd6);
    check_hit("op2.idx10kept", 1, 1'b1, 10, 20'h0000A, PS_4K, 1'b0);
    invtlb(INV_NG_ASID_VA, 10'd6, 19'h50001);
    search(1, 19'h50000, 1'b0, 10'd6);
    check_hit("op5.vamiss", 1, 1'b1, 10, 20'h0000A, PS_4K, 1'b0);
    invtlb(INV_NG_ASID_VA, 10'd6, 19'h50000);
    search(1, 19'h50000, 1'b0, 10'd6);
    check_hit("op5.hit", 1, 1'b0, 0, 20'h0, 6'd0, 1'b0);

    // read port, including the odd-ps store rule and a cleared entry
    write_entry(5, 19'h70000, 6'd15, 10'd0, 1'b0, 20'h00005, 20'h10005);
    r_index = 4'd5;
    #1;
    check_output("rd5.ps", 32'(r_ps), 32'd12);
    check_output("rd5.e", 32'(r_e), 32'd1);
    check_output("rd5.vppn", 32'(r_vppn), 32'h70000);
    r_index = 4'd7;
    #1;
    check_output("rd7.ps", 32'(r_ps), 32'd21);
    check_output("rd7.e", 32'(r_e), 32'd0);
    check_output("rd7.ppn1", 32'(r_ppn1), 32'h33333);

    // write and flush-all in the same cycle: only the written entry survives
    invtlb_valid = 1'b1; invtlb_op = INV_ALL0;
    write_entry(4, 19'h60000, PS_4K, 10'd2, 1'b1, 20'h04040, 20'h44444);
    invtlb_valid = 1'b0;
    r_index = 4'd4;
    #1;
    check_output("wi.r_e4", 32'(r_e), 32'd1);
    r_index = 4'd5;
    #1;
    check_output("wi.r_e5", 32'(r_e), 32'd0);
    r_index = 4'd2;
    #1;
    check_output("wi.r_e2", 32'(r_e), 32'd0);
    search(0, 19'h60000, 1'b1, 10'd7);
    check_hit("wi.idx4", 0, 1'b1, 4, 20'h44444, PS_4K, 1'b0);
    search(1, 19'h40000, 1'b0, 10'd1);
    check_hit("wi.idx2gone", 1, 1'b0, 0, 20'h0, 6'd0, 1'b0);

    // fill index: holds without fill_adv, steps once per pulse
    check_output("fill.start", 32'(fill_index), 32'(fill_m[IDXW-1:0]));
    for (int i = 0; i < TLBNUM; i++) begin
      fill_adv = 1'b1;
      tick();
      fill_adv = 1'b0;
      fill_m = fill_step(fill_m);
      check_output($sformatf("fill.step%0d", i), 32'(fill_index), 32'(fill_m[IDXW-1:0]));
    end
    tick();
    check_output("fill.hold", 32'(fill_index), 32'(fill_m[IDXW-1:0]));
    for (int i = 0; i < 3; i++) begin
      fill_adv = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fill_adv = 1'b0;
    fill_m = fill_seed();
    check_output("fill.reset", 32'(fill_index), 32'(fill_m[IDXW-1:0]));
    search(0, 19'h60000, 1'b1, 10'd7);
    check_hit("reset.miss", 0, 1'b0, 0, 20'h0, 6'd0, 1'b0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // run-time bound in case the clock or a wait ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
